// File: rtl/fdct_row_if.sv
// fdct_row_if: streaming bus for the forward DCT row stage.
//   master side (block feeder) drives: in_valid, size4, x_in
//   slave side (fdct_row) drives:      y_out, y_valid, y_idx, y_last, y_size4
//   in_valid : one residual sample x_in offered this cycle, always accepted
//   size4    : 1 = 4-point block, 0 = 8-point; only looked at on a block's first sample
//   x_in     : signed residual sample, natural order within the block
//   y_out    : signed coefficient Y[k]
//   y_valid  : y_out / y_idx / y_last / y_size4 are valid
//   y_idx    : k of the current coefficient
//   y_last   : marks the final coefficient of a burst
//   y_size4  : size of the block the current burst belongs to
interface fdct_row_if #(
    parameter int WIDTH_X = 16
);
    logic                      in_valid;
    logic                      size4;
    logic signed [WIDTH_X-1:0] x_in;
    logic signed [WIDTH_X-1:0] y_out;
    logic                      y_valid;
    logic [2:0]                y_idx;
    logic                      y_last;
    logic                      y_size4;

    modport master (
        output in_valid, size4, x_in,
        input  y_out, y_valid, y_idx, y_last, y_size4
    );

    modport slave (
        input  in_valid, size4, x_in,
        output y_out, y_valid, y_idx, y_last, y_size4
    );
endinterface

// File: rtl/fdct_row.sv
// fdct_row: first (row) stage of the 4/8-point HEVC forward integer DCT.
// One residual sample is accepted per in_valid cycle. Every coefficient
// accumulator is updated with a shift-add constant product of that sample, so
// the whole block is transformed by the time its last sample has passed.
// Sums are rounded, arithmetically shifted and saturated into a double buffer
// and streamed out serially (Y[0]..Y[N-1]) while the next block accumulates.
//
// Pipeline (last sample accepted at edge T):
//   T   : input register (sample, index n, block size, last flag)
//   T+1 : the seven constant products of the sample
//   T+2 : accumulator update
//   T+3 : round/shift/saturate into the output buffer, serializer restarts
//   T+4 : Y[0] on y_out, then one coefficient per cycle
//
// Ports: clk, rst_n (synchronous, active-low), bus (fdct_row_if.slave).
//
// An 8-point block followed by a 4-point block needs at least 4 idle input
// cycles between them, otherwise the 4-point result lands in the buffer
// before the 8-point burst has been fully read out.
module fdct_row #(
    parameter int WIDTH_X   = 16,
    parameter int WIDTH_ACC = 27,
    parameter int SHIFT_ROW = 2,
    parameter int ADD_ROW   = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    fdct_row_if.slave bus
);
    typedef logic signed [WIDTH_ACC-1:0] acc_t;
    typedef logic signed [WIDTH_X-1:0]   smp_t;
    typedef enum logic {IDLE, SEND} state_t;

    localparam acc_t ADD_C   = acc_t'(ADD_ROW);
    localparam acc_t SAT_MAX = acc_t'((1 << (WIDTH_X - 1)) - 1);
    localparam acc_t SAT_MIN = ~SAT_MAX;

    // Coefficient matrices, row k, column n.
    localparam int C8 [0:63] = '{
        64,  64,  64,  64,  64,  64,  64,  64,
        89,  75,  50,  18, -18, -50, -75, -89,
        83,  36, -36, -83, -83, -36,  36,  83,
        75, -18, -89, -50,  50,  89,  18, -75,
        64, -64, -64,  64,  64, -64, -64,  64,
        50, -89,  18,  75, -75, -18,  89, -50,
        36, -83,  83, -36, -36,  83, -83,  36,
        18, -50,  75, -89,  89, -75,  50, -18
    };
    localparam int C4 [0:15] = '{
        64,  64,  64,  64,
        83,  36, -36, -83,
        64, -64, -64,  64,
        36, -83,  83, -36
    };

    // Maps a coefficient to {negate, product index}. Product indices follow the
    // order of prod_next below; index 7 is the all-zero entry.
    function automatic logic [3:0] coef_sel(input int c);
        logic [3:0] r;
        r = 4'b0111;
        case (c)
            64,  -64: r[2:0] = 3'd0;
            89,  -89: r[2:0] = 3'd1;
            83,  -83: r[2:0] = 3'd2;
            75,  -75: r[2:0] = 3'd3;
            50,  -50: r[2:0] = 3'd4;
            36,  -36: r[2:0] = 3'd5;
            18,  -18: r[2:0] = 3'd6;
            default:  r[2:0] = 3'd7;
        endcase
        r[3] = (c < 0);
        return r;
    endfunction

    // ---------------- input register ----------------
    logic [2:0] n_reg;
    logic       blk4_reg;
    logic       cur4;
    logic       in_last;

    // The block size comes straight from the port on the first sample and from
    // the latched copy for the rest of the block.
    assign cur4    = (n_reg == 3'd0) ? bus.size4 : blk4_reg;
    assign in_last = cur4 ? (n_reg == 3'd3) : (n_reg == 3'd7);

    logic       s0_valid_reg;
    logic       s0_size4_reg;
    logic       s0_last_reg;
    logic [2:0] s0_n_reg;
    smp_t       s0_x_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_reg        <= 3'd0;
            blk4_reg     <= 1'b0;
            s0_valid_reg <= 1'b0;
            s0_size4_reg <= 1'b0;
            s0_last_reg  <= 1'b0;
            s0_n_reg     <= 3'd0;
            s0_x_reg     <= '0;
        end else begin
            s0_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s0_x_reg     <= bus.x_in;
                s0_n_reg     <= n_reg;
                s0_size4_reg <= cur4;
                s0_last_reg  <= in_last;
                n_reg        <= in_last ? 3'd0 : n_reg + 3'd1;
                if (n_reg == 3'd0) begin
                    blk4_reg <= bus.size4;
                end
            end
        end
    end

    // ---------------- stage 1: constant products ----------------
    acc_t xe;
    acc_t prod_next   [0:7];
    acc_t s1_prod_reg [0:7];
    logic       s1_valid_reg;
    logic       s1_size4_reg;
    logic       s1_last_reg;
    logic [2:0] s1_n_reg;

    assign xe = {{(WIDTH_ACC - WIDTH_X){s0_x_reg[WIDTH_X-1]}}, s0_x_reg};

    assign prod_next[0] = xe <<< 6;                                    // 64
    assign prod_next[1] = (xe <<< 6) + (xe <<< 4) + (xe <<< 3) + xe;   // 89
    assign prod_next[2] = (xe <<< 6) + (xe <<< 4) + (xe <<< 1) + xe;   // 83
    assign prod_next[3] = (xe <<< 6) + (xe <<< 3) + (xe <<< 1) + xe;   // 75
    assign prod_next[4] = (xe <<< 5) + (xe <<< 4) + (xe <<< 1);        // 50
    assign prod_next[5] = (xe <<< 5) + (xe <<< 2);                     // 36
    assign prod_next[6] = (xe <<< 4) + (xe <<< 1);                     // 18
    assign prod_next[7] = '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_size4_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_n_reg     <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                s1_prod_reg[i] <= '0;
            end
        end else begin
            s1_valid_reg <= s0_valid_reg;
            if (s0_valid_reg) begin
                s1_size4_reg <= s0_size4_reg;
                s1_last_reg  <= s0_last_reg;
                s1_n_reg     <= s0_n_reg;
                for (int i = 0; i < 8; i++) begin
                    s1_prod_reg[i] <= prod_next[i];
                end
            end
        end
    end

    // ---------------- stage 2: accumulation ----------------
    acc_t term    [0:7];
    acc_t acc_reg [0:7];
    logic s2_load_reg;
    logic s2_size4_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_term
            logic [3:0] sel8;
            logic [3:0] sel4;
            logic [3:0] sel;
            acc_t       mag;

            assign sel8 = coef_sel(C8[{3'(gi), s1_n_reg}]);
            if (gi < 4) begin : g_has4
                assign sel4 = coef_sel(C4[{2'(gi), s1_n_reg[1:0]}]);
            end else begin : g_no4
                assign sel4 = 4'b0111;
            end
            assign sel      = s1_size4_reg ? sel4 : sel8;
            assign mag      = s1_prod_reg[sel[2:0]];
            assign term[gi] = sel[3] ? -mag : mag;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_load_reg  <= 1'b0;
            s2_size4_reg <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                acc_reg[k] <= '0;
            end
        end else begin
            s2_load_reg <= s1_valid_reg && s1_last_reg;
            if (s1_valid_reg) begin
                s2_size4_reg <= s1_size4_reg;
                // The first sample of a block restarts from the rounding offset.
                for (int k = 0; k < 8; k++) begin
                    if (k < 4 || !s1_size4_reg) begin
                        acc_reg[k] <= ((s1_n_reg == 3'd0) ? ADD_C : acc_reg[k]) + term[k];
                    end
                end
            end
        end
    end

    // ---------------- stage 3: shift, saturate, buffer ----------------
    smp_t sat_w      [0:7];
    smp_t outbuf_reg [0:7];
    logic buf4_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_sat
            acc_t shifted;
            assign shifted   = acc_reg[gi] >>> SHIFT_ROW;
            assign sat_w[gi] = (shifted > SAT_MAX) ? SAT_MAX[WIDTH_X-1:0] :
                               (shifted < SAT_MIN) ? SAT_MIN[WIDTH_X-1:0] :
                                                     shifted[WIDTH_X-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf4_reg <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                outbuf_reg[k] <= '0;
            end
        end else if (s2_load_reg) begin
            buf4_reg <= s2_size4_reg;
            for (int k = 0; k < 8; k++) begin
                if (k < 4 || !s2_size4_reg) begin
                    outbuf_reg[k] <= sat_w[k];
                end
            end
        end
    end

    // ---------------- output serializer ----------------
    state_t     state_reg;
    logic [2:0] k_reg;
    logic [2:0] k_last;
    smp_t       y_out_reg;
    logic       y_valid_reg;
    logic [2:0] y_idx_reg;
    logic       y_last_reg;
    logic       y_size4_reg;

    assign k_last = buf4_reg ? 3'd3 : 3'd7;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            k_reg       <= 3'd0;
            y_out_reg   <= '0;
            y_valid_reg <= 1'b0;
            y_idx_reg   <= 3'd0;
            y_last_reg  <= 1'b0;
            y_size4_reg <= 1'b0;
        end else begin
            case (state_reg)
                SEND: begin
                    y_out_reg   <= outbuf_reg[k_reg];
                    y_valid_reg <= 1'b1;
                    y_idx_reg   <= k_reg;
                    y_last_reg  <= (k_reg == k_last);
                    y_size4_reg <= buf4_reg;
                    if (k_reg == k_last) begin
                        state_reg <= IDLE;
                    end else begin
                        k_reg <= k_reg + 3'd1;
                    end
                end
                default: begin
                    y_valid_reg <= 1'b0;
                    y_last_reg  <= 1'b0;
                end
            endcase
            // A fresh buffer load overrides the end of the previous burst, so
            // back-to-back blocks stream without an idle cycle. The final read
            // above still sees the old buffer contents.
            if (s2_load_reg) begin
                state_reg <= SEND;
                k_reg     <= 3'd0;
            end
        end
    end

    assign bus.y_out   = y_out_reg;
    assign bus.y_valid = y_valid_reg;
    assign bus.y_idx   = y_idx_reg;
    assign bus.y_last  = y_last_reg;
    assign bus.y_size4 = y_size4_reg;
endmodule

// File: tb/tb_fdct_row.sv
// tb_fdct_row: directed self-checking bench for fdct_row (SHIFT_ROW=2, ADD_ROW=2).
module tb_fdct_row;
    localparam int TB_SHIFT = 2;
    localparam int TB_ADD   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fdct_row_if #(.WIDTH_X(16)) bus_if ();

    fdct_row #(
        .WIDTH_X  (16),
        .WIDTH_ACC(27),
        .SHIFT_ROW(TB_SHIFT),
        .ADD_ROW  (TB_ADD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int y; int idx; int last; int s4; } obs_t;
    typedef struct { int y; int idx; int last; int s4; } exp_t;
    obs_t obs_q[$];
    exp_t exp_q[$];

    always @(negedge clk) begin
        if (bus_if.y_valid === 1'b1) begin
            obs_q.push_back('{cyc, int'(bus_if.y_out), int'(bus_if.y_idx),
                              int'(bus_if.y_last), int'(bus_if.y_size4)});
        end
    end

    int C8 [8][8] = '{
        '{64,  64,  64,  64,  64,  64,  64,  64},
        '{89,  75,  50,  18, -18, -50, -75, -89},
        '{83,  36, -36, -83, -83, -36,  36,  83},
        '{75, -18, -89, -50,  50,  89,  18, -75},
        '{64, -64, -64,  64,  64, -64, -64,  64},
        '{50, -89,  18,  75, -75, -18,  89, -50},
        '{36, -83,  83, -36, -36,  83, -83,  36},
        '{18, -50,  75, -89,  89, -75,  50, -18}
    };
    int C4 [4][4] = '{
        '{64,  64,  64,  64},
        '{83,  36, -36, -83},
        '{64, -64, -64,  64},
        '{36, -83,  83, -36}
    };

    int checks = 0;
    int failures = 0;
    int blk_x [8];
    int exp_y [8];
    int last_acc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int sizes [3] = '{1, 0, 1};

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int x, input int s4);
        bus_if.in_valid = 1'b1;
        bus_if.x_in     = x[15:0];
        bus_if.size4    = s4[0];
        @(negedge clk);
        last_acc        = cyc;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus_if.in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus_if.x_in = 16'($urandom);
            @(negedge clk);
        end
    endtask

    function automatic void ref_calc(input int s4);
        int n;
        longint acc;
        n = (s4 != 0) ? 4 : 8;
        for (int k = 0; k < 8; k++) exp_y[k] = 0;
        for (int k = 0; k < n; k++) begin
            acc = TB_ADD;
            for (int i = 0; i < n; i++) begin
                if (s4 != 0) acc += longint'(C4[k][i]) * longint'(blk_x[i]);
                else         acc += longint'(C8[k][i]) * longint'(blk_x[i]);
            end
            acc = acc >>> TB_SHIFT;
            if (acc > 32767) acc = 32767;
            else if (acc < -32768) acc = -32768;
            exp_y[k] = int'(acc);
        end
    endfunction

    task automatic push_block(input int n, input int s4);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.y    = exp_y[k];
            e.idx  = k;
            e.last = (k == n - 1) ? 1 : 0;
            e.s4   = s4;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_outs(input int n, input string tag);
        int   waited;
        obs_t o;
        exp_t e;
        waited = 0;
        while (obs_q.size() < n && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("%s_count", tag), (obs_q.size() < n) ? obs_q.size() : n, n);
        for (int i = 0; i < n; i++) begin
            if (obs_q.size() == 0 || exp_q.size() == 0) break;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (i == 0) first_cyc = o.cyc;
            last_cyc = o.cyc;
            check($sformatf("%s_y%0d", tag, i),    o.y,    e.y);
            check($sformatf("%s_idx%0d", tag, i),  o.idx,  e.idx);
            check($sformatf("%s_last%0d", tag, i), o.last, e.last);
            check($sformatf("%s_s4_%0d", tag, i),  o.s4,   e.s4);
        end
    endtask

    initial begin
        bus_if.in_valid = 1'b0;
        bus_if.size4    = 1'b0;
        bus_if.x_in     = '0;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_y_valid", bus_if.y_valid, 0);
        check("rst_y_out",   bus_if.y_out,   0);
        check("rst_y_idx",   bus_if.y_idx,   0);
        check("rst_y_last",  bus_if.y_last,  0);
        check("rst_y_size4", bus_if.y_size4, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: 8pt DC 10 -> (2+5120)>>>2 = 1280, rest 0; Y0 four edges after last accept
        for (int i = 0; i < 8; i++) send(10, 0);
        exp_y = '{1280, 0, 0, 0, 0, 0, 0, 0};
        push_block(8, 0);
        check_outs(8, "dc8");
        check("dc8_latency", first_cyc - last_acc, 4);
        $display("tb: 8pt DC block checked");

        // 2: 4pt impulse 100 (size4 low on later samples must be ignored)
        send(100, 1);
        send(0, 0);
        send(0, 0);
        send(0, 0);
        exp_y = '{1600, 2075, 1600, 900, 0, 0, 0, 0};
        push_block(4, 1);
        check_outs(4, "imp4");
        $display("tb: 4pt impulse block checked");

        // 3: back-to-back 8pt ramp then DC 10, no gaps
        for (int i = 0; i < 8; i++) send(i, 0);
        for (int i = 0; i < 8; i++) send(10, 0);
        exp_y = '{448, -291, 0, -29, 0, -8, 0, -3};
        push_block(8, 0);
        exp_y = '{1280, 0, 0, 0, 0, 0, 0, 0};
        push_block(8, 0);
        check_outs(16, "b2b");
        check("b2b_span", last_cyc - first_cyc, 15);
        $display("tb: back-to-back ramp/DC blocks checked");

        // 4: saturation at both rails
        for (int i = 0; i < 8; i++) send(32767, 0);
        for (int i = 0; i < 8; i++) send(-32768, 0);
        exp_y = '{32767, 0, 0, 0, 0, 0, 0, 0};
        push_block(8, 0);
        exp_y = '{-32768, 0, 0, 0, 0, 0, 0, 0};
        push_block(8, 0);
        check_outs(16, "sat");
        $display("tb: saturation blocks checked");

        // 5: random samples with gaps, 4pt / 8pt / 4pt
        for (int b = 0; b < 3; b++) begin
            int n;
            n = (sizes[b] != 0) ? 4 : 8;
            for (int i = 0; i < n; i++) begin
                int x;
                x = int'($urandom_range(65535)) - 32768;
                blk_x[i] = x;
                send(x, (i == 0) ? sizes[b] : int'($urandom_range(1)));
                if (i != n - 1) idle(int'($urandom_range(2)));
            end
            ref_calc(sizes[b]);
            push_block(n, sizes[b]);
            idle(4);
        end
        check_outs(16, "rnd");
        $display("tb: random gapped 4/8/4 blocks checked");

        // 6: reset mid-block discards the partial block
        idle(2);
        send(50, 0);
        send(60, 0);
        send(70, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_y_valid", bus_if.y_valid, 0);
        check("mid_rst_y_out",   bus_if.y_out,   0);
        check("mid_rst_y_idx",   bus_if.y_idx,   0);
        check("mid_rst_y_size4", bus_if.y_size4, 0);
        idle(12);
        check("mid_rst_no_output", obs_q.size(), 0);
        obs_q.delete();
        for (int i = 0; i < 8; i++) begin
            blk_x[i] = int'($urandom_range(4000)) - 2000;
            send(blk_x[i], 0);
        end
        ref_calc(0);
        push_block(8, 0);
        check_outs(8, "post_rst");
        $display("tb: mid-block reset recovery checked");

        idle(12);
        check("tail_empty", obs_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
